// File: rtl/rmst_pkg.sv
// Shared types and defaults for the Avalon read-master tiling controller.
package rmst_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONFIG = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_NEXT   = 3'd4,
      ST_FIN    = 3'd5
   } state_e;

   localparam int TILE_LEN_DEF = 128;
   localparam int WS_DEF       = 2;

   function automatic int unsigned umin(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/rmst_tile_ctrl_if.sv
// Transfer-engine handshake: controller (master) requests bursts, engine (slave) reports completion.
interface rmst_tile_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 12
);
   logic          trans_start;
   logic [DW-1:0] trans_addr;
   logic [AW-1:0] trans_len;
   logic          trans_done;

   modport master (output trans_start, trans_addr, trans_len, input trans_done);
   modport slave  (input trans_start, trans_addr, trans_len, output trans_done);
endinterface

// File: rtl/rmst_addr_gen.sv
// Walks the 2-D tile geometry: tracks row base, offset in row, words left in row and rows done.
module rmst_addr_gen
   import rmst_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 12,
   parameter int RW       = 10,
   parameter int TILE_LEN = TILE_LEN_DEF,
   parameter int WS       = WS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [DW-1:0] cfg_base_addr,
   input  logic [AW-1:0] cfg_row_len,
   input  logic [RW-1:0] cfg_row_num,
   input  logic [DW-1:0] cfg_row_stride,
   output logic [DW-1:0] next_addr,
   output logic [AW-1:0] next_len,
   output logic          last
);

   logic [DW-1:0] row_addr_q, row_addr_d, offset_q, offset_d, stride_q, stride_d;
   logic [AW-1:0] remaining_q, remaining_d, row_len_q, row_len_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d, row_num_q, row_num_d;
   logic          row_end;

   always_comb begin
      next_addr   = row_addr_q + offset_q;
      next_len    = AW'(umin(32'(remaining_q), 32'(TILE_LEN)));
      row_end     = (remaining_q == next_len);
      // row_cnt never exceeds row_num-1 while running, so the +1 cannot wrap
      last        = row_end && ((row_cnt_q + RW'(1)) == row_num_q);
      row_addr_d  = row_addr_q;
      offset_d    = offset_q;
      remaining_d = remaining_q;
      row_cnt_d   = row_cnt_q;
      row_len_d   = row_len_q;
      row_num_d   = row_num_q;
      stride_d    = stride_q;
      if (load) begin
         row_addr_d  = cfg_base_addr;
         offset_d    = '0;
         remaining_d = cfg_row_len;
         row_cnt_d   = '0;
         row_len_d   = cfg_row_len;
         row_num_d   = cfg_row_num;
         stride_d    = cfg_row_stride;
      end else if (step) begin
         remaining_d = remaining_q - next_len;
         offset_d    = offset_q + (DW'(next_len) << WS);
         if (row_end) begin
            row_cnt_d   = row_cnt_q + RW'(1);
            row_addr_d  = row_addr_q + stride_q;
            offset_d    = '0;
            remaining_d = row_len_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_addr_q  <= '0;
         offset_q    <= '0;
         remaining_q <= '0;
         row_cnt_q   <= '0;
         row_len_q   <= '0;
         row_num_q   <= '0;
         stride_q    <= '0;
      end else begin
         row_addr_q  <= row_addr_d;
         offset_q    <= offset_d;
         remaining_q <= remaining_d;
         row_cnt_q   <= row_cnt_d;
         row_len_q   <= row_len_d;
         row_num_q   <= row_num_d;
         stride_q    <= stride_d;
      end
   end

endmodule

// File: rtl/rmst_tile_ctrl.sv
// Read-master tiling controller: splits a rows x row_len load into bursts of at most TILE_LEN words.
// Optional RMST_TILE_PERF_CNT_EN adds perf_cycles / perf_trans counters.
module rmst_tile_ctrl
   import rmst_pkg::*;
#(
   parameter int DW       = 32,
   parameter int AW       = 12,
   parameter int RW       = 10,
   parameter int TILE_LEN = TILE_LEN_DEF,
   parameter int WS       = WS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [DW-1:0] cfg_base_addr,
   input  logic [AW-1:0] cfg_row_len,
   input  logic [RW-1:0] cfg_row_num,
   input  logic [DW-1:0] cfg_row_stride,
   output logic          load_busy,
   output logic          load_done,
   output logic          load_err,
   rmst_tile_ctrl_if.master trans
`ifdef RMST_TILE_PERF_CNT_EN
   ,
   output logic [31:0]   perf_cycles,
   output logic [15:0]   perf_trans
`endif
);

   state_e        state_q, state_d;
   logic          err_q, err_d;
   logic [DW-1:0] trans_addr_q, trans_addr_d;
   logic [AW-1:0] trans_len_q, trans_len_d;
   logic          ag_load, ag_step, ag_last;
   logic [DW-1:0] ag_addr;
   logic [AW-1:0] ag_len;

   rmst_addr_gen #(
      .DW(DW), .AW(AW), .RW(RW), .TILE_LEN(TILE_LEN), .WS(WS)
   ) u_addr_gen (
      .clk           (clk),
      .rst           (rst),
      .load          (ag_load),
      .step          (ag_step),
      .cfg_base_addr (cfg_base_addr),
      .cfg_row_len   (cfg_row_len),
      .cfg_row_num   (cfg_row_num),
      .cfg_row_stride(cfg_row_stride),
      .next_addr     (ag_addr),
      .next_len      (ag_len),
      .last          (ag_last)
   );

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      trans_addr_d = trans_addr_q;
      trans_len_d  = trans_len_q;
      ag_load      = 1'b0;
      ag_step      = 1'b0;
      case (state_q)
         ST_IDLE: if (load_start) begin
            ag_load = 1'b1;
            err_d   = (cfg_row_len == '0) || (cfg_row_num == '0);
            state_d = err_d ? ST_FIN : ST_CONFIG;
         end
         ST_CONFIG: begin
            trans_len_d  = ag_len;
            trans_addr_d = ag_addr;
            state_d      = ST_ISSUE;
         end
         // trans_done is deliberately not looked at here: a pulse during ISSUE is a protocol violation
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (trans.trans_done) state_d = ST_NEXT;
         ST_NEXT: begin
            ag_step = 1'b1;
            state_d = ag_last ? ST_FIN : ST_CONFIG;
         end
         ST_FIN: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         err_q        <= 1'b0;
         trans_addr_q <= '0;
         trans_len_q  <= '0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         trans_addr_q <= trans_addr_d;
         trans_len_q  <= trans_len_d;
      end
   end

   assign load_busy         = (state_q != ST_IDLE);
   assign load_done         = (state_q == ST_FIN);
   assign load_err          = (state_q == ST_FIN) && err_q;
   assign trans.trans_start = (state_q == ST_ISSUE);
   assign trans.trans_addr  = trans_addr_q;
   assign trans.trans_len   = trans_len_q;

`ifdef RMST_TILE_PERF_CNT_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [15:0] perf_trans_q, perf_trans_d;

   // the accept cycle itself counts, hence restart at 1
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_trans_d  = perf_trans_q;
      if (ag_load) begin
         perf_cycles_d = 32'd1;
         perf_trans_d  = '0;
      end else if (state_q != ST_IDLE) begin
         if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
         if (state_q == ST_ISSUE) perf_trans_d = perf_trans_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_trans_q  <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_trans_q  <= perf_trans_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_trans  = perf_trans_q;
`endif

endmodule

// File: tb/tb_rmst_tile_ctrl.sv
// Randomized bench for rmst_tile_ctrl against a queue-based model of the tiled transfer list.
module tb_rmst_tile_ctrl;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int RW = 10;
   localparam int TL = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic [DW-1:0] cfg_base_addr = '0;
   logic [AW-1:0] cfg_row_len = '0;
   logic [RW-1:0] cfg_row_num = '0;
   logic [DW-1:0] cfg_row_stride = '0;
   logic          load_busy, load_done, load_err;
`ifdef RMST_TILE_PERF_CNT_EN
   logic [31:0]   perf_cycles;
   logic [15:0]   perf_trans;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rmst_tile_ctrl_if #(.DW(DW), .AW(AW)) tif ();

   rmst_tile_ctrl #(.DW(DW), .AW(AW), .RW(RW), .TILE_LEN(TL), .WS(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (load_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_row_len   (cfg_row_len),
      .cfg_row_num   (cfg_row_num),
      .cfg_row_stride(cfg_row_stride),
      .load_busy     (load_busy),
      .load_done     (load_done),
      .load_err      (load_err),
      .trans         (tif.master)
`ifdef RMST_TILE_PERF_CNT_EN
      ,
      .perf_cycles   (perf_cycles),
      .perf_trans    (perf_trans)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller sits #1 after an edge with the DUT idle.
   task automatic run_load(input logic [31:0] base, input int rlen, input int rnum,
                           input logic [31:0] stride, input bit poke_start);
      logic [31:0] qa[$];
      int          ql[$];
      logic [31:0] a;
      int          ntr, cyc, last_done, done_at;
      bit          err, waiting, finished;

      err = (rlen == 0) || (rnum == 0);
      if (!err)
         for (int r = 0; r < rnum; r++)
            for (int off = 0; off < rlen; off += TL) begin
               a = base + stride * 32'(r) + (32'(off) << 2);
               qa.push_back(a);
               ql.push_back((rlen - off < TL) ? rlen - off : TL);
            end
      ntr = ql.size();

      load_start     = 1'b1;
      cfg_base_addr  = base;
      cfg_row_len    = AW'(rlen);
      cfg_row_num    = RW'(rnum);
      cfg_row_stride = stride;
      tick();
      load_start     = 1'b0;
      cfg_base_addr  = $urandom;
      cfg_row_len    = AW'($urandom);
      cfg_row_num    = RW'($urandom);
      cfg_row_stride = $urandom;

      cyc = 1; last_done = -1; done_at = -1; waiting = 0; finished = 0;
      while (!finished && cyc < 5000) begin
         tif.trans_done = 1'b0;
         load_start     = poke_start;
         chk("busy", load_busy, 1);
         if (load_done) begin
            chk("err", load_err, err);
            chk("done_lat", cyc - ((last_done < 0) ? 0 : last_done), (last_done < 0) ? 1 : 2);
            chk("left", qa.size(), 0);
            finished   = 1;
            load_start = 1'b0;
         end else if (tif.trans_start) begin
            if (qa.size() == 0) chk("extra_trans", 1, 0);
            else begin
               chk("addr", tif.trans_addr, qa.pop_front());
               chk("len", tif.trans_len, ql.pop_front());
            end
            chk("start_lat", cyc - ((last_done < 0) ? 0 : last_done), (last_done < 0) ? 2 : 3);
            waiting = 1;
            done_at = cyc + 1 + int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tif.trans_done = 1'b1;
         end else if (waiting) begin
            if (cyc == done_at) begin
               tif.trans_done = 1'b1;
               waiting        = 0;
               last_done      = cyc;
            end
         end else if ($urandom_range(0, 2) == 0) tif.trans_done = 1'b1;
         if (!finished) begin
            tick();
            cyc++;
         end
      end
      if (!finished) chk("timeout", 0, 1);
      tif.trans_done = 1'b0;
      tick();
      chk("idle_busy", load_busy, 0);
      chk("idle_done", load_done, 0);
`ifdef RMST_TILE_PERF_CNT_EN
      chk("perf_trans", perf_trans, ntr);
      chk("perf_cycles", perf_cycles, cyc + 1);
`endif
      tick();
      tick();
      chk("idle_start", tif.trans_start, 0);
      chk("idle_busy2", load_busy, 0);
   endtask

   initial begin
      tif.trans_done = 1'b0;
      tick();
      tick();
      chk("rst_busy", load_busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_start", tif.trans_start, 0);
      chk("rst_addr", tif.trans_addr, 0);
      chk("rst_len", tif.trans_len, 0);
`ifdef RMST_TILE_PERF_CNT_EN
      chk("rst_perf_c", perf_cycles, 0);
      chk("rst_perf_t", perf_trans, 0);
`endif
      rst = 1'b0;
      tick();

      run_load(32'h0000_1000, 1024, 1, 32'h0, 0);
      run_load(32'h0000_0000, 300, 1, 32'h0, 0);
      run_load(32'h0000_0100, 64, 3, 32'h1000, 0);
      run_load(32'h0000_0000, 0, 5, 32'h40, 0);
      run_load(32'hFFFF_FF00, 256, 1, 32'h0, 1);

      // reset in WAIT abandons the transfer; its late trans_done must be ignored
      load_start     = 1'b1;
      cfg_base_addr  = 32'h40;
      cfg_row_len    = 12'd64;
      cfg_row_num    = 10'd2;
      cfg_row_stride = 32'h100;
      tick();
      load_start = 1'b0;
      tick();
      chk("mid_start", tif.trans_start, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", load_busy, 0);
      chk("mid_addr", tif.trans_addr, 0);
      chk("mid_len", tif.trans_len, 0);
      tif.trans_done = 1'b1;
      tick();
      tif.trans_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("mid_idle", {load_busy, load_done, load_err, tif.trans_start}, 0);
         tick();
      end
      run_load(32'h40, 64, 2, 32'h100, 0);

      for (int i = 0; i < 10; i++)
         run_load($urandom, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 600)),
                  int'($urandom_range(0, 4)), $urandom, bit'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rmst_tile_ctrl.md
Name: rmst_tile_ctrl

Overview:
- Parametrised Avalon read-master tiling controller. Splits a 2-D load of `cfg_row_num` rows × `cfg_row_len` words into per-transfer bursts of at most `TILE_LEN` words, with row stride in bytes.
- Drives the read-master transfer engine (`trans_start`/`trans_addr`/`trans_len`, handshaked by `trans_done`).
- Reports completion, busy and configuration error to the upper layer-load sequencer.
- Base, length and geometry are runtime inputs, not elaboration constants.

Parameters:
- DW, 32, byte-address width of `cfg_base_addr`, `cfg_row_stride`, `trans_addr`.
- AW, 12, word-count width of `cfg_row_len` and `trans_len`.
- RW, 10, row-count width of `cfg_row_num`.
- TILE_LEN, 128, maximum words per transfer; must be at most 2^AW-1.
- WS, 2, log2 bytes per word; byte offset = words << WS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  request pulse; accepted only in IDLE.
- cfg_base_addr  in  DW  byte address of row 0; sampled at accept.
- cfg_row_len  in  AW  words per row; sampled at accept.
- cfg_row_num  in  RW  number of rows; sampled at accept.
- cfg_row_stride  in  DW  byte distance between row starts; sampled at accept.
- load_busy  out  1  high from the cycle after accept until the load_done cycle, inclusive.
- load_done  out  1  one-cycle completion pulse.
- load_err  out  1  one-cycle pulse, coincident with load_done, when the accepted config has cfg_row_len==0 or cfg_row_num==0.
- trans_start  out  1  one-cycle transfer request.
- trans_addr  out  DW  byte address of the current transfer; stable from CONFIG exit until the next CONFIG.
- trans_len  out  AW  word count of the current transfer, 1..TILE_LEN; stable like trans_addr.
- trans_done  in  1  pulse from the transfer engine; honoured only in WAIT.

Behaviour:
- Reset values: every output 0, state IDLE, all internal counters 0.
- State machine: IDLE, CONFIG, ISSUE, WAIT, NEXT, FIN.
- IDLE:
  - On load_start, latch all cfg_* inputs, set row_addr=base, offset=0, remaining=row_len, row_cnt=0.
  - If row_len==0 or row_num==0, go to FIN with the error flag set; otherwise go to CONFIG.
- CONFIG:
  - trans_len <= min(remaining, TILE_LEN).
  - trans_addr <= row_addr + offset, modulo 2^DW.
  - Go to ISSUE.
- ISSUE: trans_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold until trans_done=1, then go to NEXT.
- NEXT:
  - remaining -= trans_len; offset += trans_len << WS.
  - If remaining becomes 0: row_cnt++, row_addr += stride (mod 2^DW), offset=0, remaining=row_len.
  - If row_cnt reaches row_num, go to FIN; otherwise go to CONFIG.
- FIN: load_done=1 (load_err=1 if the error flag is set) for one cycle; clear the error flag; go to IDLE.
- Latency:
  - load_start to first trans_start: 2 cycles.
  - trans_done to next trans_start: 3 cycles.
  - last trans_done to load_done: 2 cycles.
  - error path: load_start to load_done/load_err: 1 cycle.
- Transfers per row = ceil(row_len / TILE_LEN). Only the final transfer of a row may be short.
- Boundary conditions:
  - load_start outside IDLE is ignored; no queueing.
  - trans_done outside WAIT is ignored.
  - trans_done coincident with the ISSUE cycle is a protocol violation and is ignored.
  - Address arithmetic wraps silently at 2^DW.
  - cfg_* changes after accept have no effect.
  - rst mid-operation returns everything to reset state next edge; any in-flight transfer is abandoned and its later trans_done is ignored.
- All outputs are decoded from registered state or registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro RMST_TILE_PERF_CNT_EN. When defined, two extra outputs are added:
  - perf_cycles [31:0]: counts cycles from accept through the load_done cycle, inclusive; saturates at all-ones.
  - perf_trans [15:0]: counts trans_start pulses.
  - Both clear on accept and hold their value in IDLE. Reset value 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rmst_pkg:
  - state encoding constants (IDLE..FIN, 3 bits);
  - default TILE_LEN;
  - WS;
  - a min() function.
- One sub-module, rmst_addr_gen:
  - holds row_addr, offset, remaining, row_cnt;
  - inputs: load, step;
  - outputs: next_addr, next_len, last.
- The FSM stays in rmst_tile_ctrl.

Test Plan:
- base=0x1000, row_len=1024, row_num=1 -> 8 transfers, len 128, addrs 0x1000, 0x1200 … 0x1E00; load_done 2 cycles after the 8th trans_done.
- base=0x0, row_len=300, row_num=1 -> lens 128, 128, 44 at addrs 0x0, 0x200, 0x400; perf_trans=3 when the macro is defined.
- base=0x100, row_len=64, row_num=3, stride=0x1000 -> addrs 0x100, 0x1100, 0x2100, each len 64; load_busy high throughout.
- row_len=0, row_num=5 -> load_done and load_err 1 cycle after start; trans_start never asserted.
- base=0xFFFFFF00, row_len=256, DW=32 -> addrs 0xFFFFFF00, 0x00000100; a second load_start during WAIT is ignored.
- rst asserted in WAIT, then trans_done pulses -> all outputs 0, no load_done; a fresh load_start afterwards completes normally.
